instr_sequencer9: RTL

Program sequencer that feeds the 9-bit `processor9` core from a small internal instruction memory. It replaces hand-driven `Run`/`DIN` stimulus: it issues each instruction with a one-cycle `Run` pulse and supplies the `mvi` immediate word on the following cycle. It then waits for the core's `Done` before advancing. It sits between a loader/host (memory write port, `Start`) and the core's `Run`, `DIN` and `Done` pins.

---
 rtl/instr_sequencer9.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instr_sequencer9.sv
// Program sequencer for the 9-bit processor9 core.
// Issues instructions from a local memory and paces them on the core's Done.
module instr_sequencer9 #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    input  logic          LoadEn,
    input  logic [AW-1:0] LoadAddr,
    input  logic [8:0]    LoadData,
    input  logic          ProcDone,
    output logic          Run,
    output logic [8:0]    DIN,
    output logic          Busy,
    output logic          Finished,
    output logic          Error,
    output logic [AW-1:0] PC
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_ERR
    } state_t;

    state_t        state;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] pc;
    logic [CW-1:0] cnt;
    logic          fin_q;

    logic [8:0]    word;
    logic [8:0]    imm_word;
    logic [2:0]    op;
    logic          is_halt;
    logic          mvi_last;
    logic          idle_like;
    logic [CW-1:0] cnt_inc;
    logic [AW:0]   adv_pc;
    logic          adv_over;

    assign word      = mem[pc];
    assign imm_word  = mem[AW'(pc + 1'b1)];
    assign op        = word[8:6];
    assign is_halt   = (op == 3'b111);
    assign mvi_last  = (op == 3'b001) && (pc == AW'(DEPTH - 1));
    assign idle_like = (state == S_IDLE) || (state == S_ERR);
    assign cnt_inc   = cnt + 1'b1;

    // An mvi that completes in IMM has consumed two words.
    assign adv_pc   = {1'b0, pc} + ((state == S_IMM) ? (AW+1)'(2) : (AW+1)'(1));
    assign adv_over = adv_pc > (AW+1)'(DEPTH - 1);

    always_ff @(posedge Clock) begin
        if (LoadEn && idle_like) begin
            mem[LoadAddr] <= LoadData;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
            pc    <= '0;
            cnt   <= '0;
            fin_q <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (state)
                S_IDLE, S_ERR: begin
                    if (Start && !LoadEn) begin
                        pc    <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt <= '0;
                    if (is_halt) begin
                        state <= S_IDLE;
                    end else if (mvi_last) begin
                        state <= S_ERR;
                    end else if (op == 3'b001) begin
                        state <= S_IMM;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_IMM, S_WAIT: begin
                    cnt <= cnt_inc;
                    if (ProcDone) begin
                        if (adv_over) begin
                            fin_q <= 1'b1;
                            pc    <= '0;
                            state <= S_IDLE;
                        end else begin
                            pc    <= adv_pc[AW-1:0];
                            state <= S_ISSUE;
                        end
                    end else if (state == S_IMM) begin
                        pc    <= pc + 1'b1;
                        state <= S_WAIT;
                    end else if (cnt_inc == CW'(TIMEOUT)) begin
                        state <= S_ERR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Run = 1'b0;
        DIN = '0;
        case (state)
            S_ISSUE: begin
                if (!is_halt && !mvi_last) begin
                    Run = 1'b1;
                    DIN = word;
                end
            end
            S_IMM:   DIN = imm_word;
            default: ;
        endcase
    end

    assign Busy     = (state == S_ISSUE) || (state == S_IMM) || (state == S_WAIT);
    assign Error    = (state == S_ERR);
    assign Finished = fin_q || ((state == S_ISSUE) && is_halt);
    assign PC       = pc;

endmodule
